div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits beside the single-cycle `alu` in the execute stage and is the iterative counterpart to the ALU's single-cycle operations. The core holds the instruction in execute while `busy` is high. The result is taken when `done` pulses. It uses radix-2 restoring division with fixed latency, and applies RISC-V special-case semantics for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder (DIV, DIVU, REM, REMU); restoring radix-2, result WIDTH+1 edges after accept.
// No backpressure: start is ignored while busy; result/zero_flag hold until the next operation completes.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       div_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] a_orig;
   logic             is_rem;
   logic             q_neg;
   logic             r_neg;
   logic             div_zero;
   logic             ovf;

   logic             accept;
   logic             calc_last;
   logic             op_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] res_fix;

   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign calc_last = (cnt == CW'(WIDTH - 1));

   // Signed ops divide magnitudes; INT_MIN negates to itself, which is the correct unsigned magnitude.
   assign op_signed = ~div_op[0];
   assign a_neg     = op_signed & a[WIDTH-1];
   assign b_neg     = op_signed & b[WIDTH-1];
   assign a_mag     = a_neg ? (~a + 1'b1) : a;
   assign b_mag     = b_neg ? (~b + 1'b1) : b;

   assign rem_sh = {rem, quo[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, divisor};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (calc_last) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CALC:    busy = 1'b1;
         FIX:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ---------------- Iteration counter ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if (state == CALC) begin
         cnt <= calc_last ? '0 : cnt + 1'b1;
      end
   end

   // ---------------- Operand capture and restoring iteration ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         a_orig   <= '0;
         is_rem   <= 1'b0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         rem      <= '0;
         quo      <= a_mag;
         divisor  <= b_mag;
         a_orig   <= a;
         is_rem   <= div_op[1];
         q_neg    <= a_neg ^ b_neg;
         r_neg    <= a_neg;
         div_zero <= (b == '0);
         ovf      <= op_signed && (a == INT_MIN) && (b == ALL_ONES);
      end else if (state == CALC) begin
         // A clear MSB means the trial subtraction did not go negative.
         if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
         end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // ---------------- Sign correction and special cases ----------------
   assign q_fix = q_neg ? (~quo + 1'b1) : quo;
   assign r_fix = r_neg ? (~rem + 1'b1) : rem;

   always_comb begin
      res_fix = is_rem ? r_fix : q_fix;
      if (div_zero) begin
         res_fix = is_rem ? a_orig : ALL_ONES;
      end else if (ovf) begin
         res_fix = is_rem ? '0 : INT_MIN;
      end
   end

   // Result only moves on the FIX->DONE edge so it stays stable through CALC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result    <= '0;
         zero_flag <= 1'b1;
      end else if (state == FIX) begin
         result    <= res_fix;
         zero_flag <= (res_fix == '0);
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, special cases, ignored start, back-to-back and mid-op reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  div_op;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero_flag;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .div_op    (div_op),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero_flag (zero_flag)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one op; lat counts edges from the accept edge to the first sample with done=1.
   // poke>0 re-pulses start with other operands so it is sampled on edge E<poke>.
   task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic [1:0] op,
                         input int poke, output logic [31:0] res, output logic zf,
                         output int lat, output logic pulse_ok, output logic quiet_ok);
      logic [31:0] held;
      @(negedge clk);
      a = aa; b = bb; div_op = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      held = result;
      quiet_ok = busy;
      lat = 0;
      res = '0;
      zf = 1'b0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         start = 1'b0;
         if (busy && done) quiet_ok = 1'b0;
         if (done) break;
         if (result !== held) quiet_ok = 1'b0;
         if (poke > 0 && lat == poke - 1) begin
            start = 1'b1; a = 32'd50; b = 32'd5; div_op = OP_DIVU;
         end
      end
      res = result;
      zf = zero_flag;
      @(posedge clk); #1;
      pulse_ok = !done && !busy && (result === res);
   endtask

   logic [31:0] r;
   logic        zf;
   int          lat;
   logic        pulse_ok;
   logic        quiet_ok;

   initial begin
      int first_done;
      int second_done;
      logic [31:0] r1;
      logic [31:0] r2;
      logic busy_at_34;
      logic spurious;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; div_op = '0;
      #12;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_result", result, 0);
      check_val("rst_zero", zero_flag, 1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      run_op(32'd100, 32'd7, OP_DIVU, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("divu_res", r, 32'd14);
      check_val("divu_lat", lat, 33);
      check_val("divu_pulse", pulse_ok, 1);
      check_val("divu_quiet", quiet_ok, 1);

      run_op(32'd100, 32'd7, OP_REMU, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("remu_res", r, 32'd2);
      check_val("remu_zero", zf, 0);
      check_val("remu_lat", lat, 33);

      run_op(32'hFFFF_FFF9, 32'd2, OP_DIV, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div_neg_res", r, 32'hFFFF_FFFD);
      run_op(32'hFFFF_FFF9, 32'd2, OP_REM, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("rem_neg_res", r, 32'hFFFF_FFFF);
      run_op(32'd7, 32'hFFFF_FFFE, OP_REM, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("rem_negb_res", r, 32'd1);
      run_op(32'd7, 32'hFFFF_FFFE, OP_DIV, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div_negb_res", r, 32'hFFFF_FFFD);

      run_op(32'd5, 32'd0, OP_DIV, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div0_div", r, 32'hFFFF_FFFF);
      check_val("div0_lat", lat, 33);
      run_op(32'd5, 32'd0, OP_DIVU, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div0_divu", r, 32'hFFFF_FFFF);
      run_op(32'd5, 32'd0, OP_REM, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div0_rem", r, 32'd5);
      run_op(32'd5, 32'd0, OP_REMU, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div0_remu", r, 32'd5);
      check_val("div0_remu_lat", lat, 33);
      run_op(32'hFFFF_FFF9, 32'd0, OP_REM, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("div0_rem_neg", r, 32'hFFFF_FFF9);

      run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("ovf_div", r, 32'h8000_0000);
      check_val("ovf_div_lat", lat, 33);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_REM, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("ovf_rem", r, 32'd0);
      check_val("ovf_rem_zero", zf, 1);

      run_op(32'd100, 32'd7, OP_DIVU, 10, r, zf, lat, pulse_ok, quiet_ok);
      check_val("ign_start_res", r, 32'd14);
      check_val("ign_start_lat", lat, 33);
      check_val("ign_start_quiet", quiet_ok, 1);

      // start held high through DONE: second op enters on the edge that leaves DONE.
      @(negedge clk);
      a = 32'd100; b = 32'd7; div_op = OP_DIVU; start = 1'b1;
      @(posedge clk); #1;
      a = 32'd9; b = 32'd3;
      first_done = -1; second_done = -1; r1 = '0; r2 = '0; busy_at_34 = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first_done < 0) begin
               first_done = i; r1 = result;
            end else if (second_done < 0) begin
               second_done = i; r2 = result;
            end
         end
         if (i == 34) begin
            busy_at_34 = busy;
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_val("b2b_first_lat", first_done, 33);
      check_val("b2b_first_res", r1, 32'd14);
      check_val("b2b_busy_e34", busy_at_34, 1);
      check_val("b2b_second_lat", second_done, 67);
      check_val("b2b_second_res", r2, 32'd3);

      @(negedge clk);
      a = 32'd100; b = 32'd7; div_op = OP_DIVU; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_done", done, 0);
      check_val("mid_rst_result", result, 0);
      check_val("mid_rst_zero", zero_flag, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      spurious = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) spurious = 1'b1;
      end
      check_val("mid_rst_no_done", spurious, 0);

      run_op(32'd9, 32'd3, OP_DIVU, 0, r, zf, lat, pulse_ok, quiet_ok);
      check_val("post_rst_res", r, 32'd3);
      check_val("post_rst_lat", lat, 33);
      check_val("post_rst_pulse", pulse_ok, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
